// File: rtl/eda_visit_tracker_pkg.sv
// Shared definitions for the visit tracker slice.
// Provides the default image geometry, the port count, the width helper used
// to size row/column/address/count fields, and the RUN/CLEAR state encoding.
package eda_visit_tracker_pkg;

  localparam int DEF_M     = 16;
  localparam int DEF_N     = 16;
  localparam int DEF_NPORT = 9;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Bits needed to encode 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/eda_visit_tracker_if.sv
// Mark/query/next-pixel bus of the visit tracker.
//   clear_req   : start a row-sequential clear of the map
//   busy        : clear in progress
//   mark_vld/addr : per-port mark strobes and {row, col} addresses
//   qry_vld/addr  : per-port query enables and addresses
//   qry_hit     : per-port visited bit
//   next_vld/row/col : first unvisited pixel in raster order
//   pop         : claim the presented next pixel
//   visited_cnt / all_visited : number of visited pixels / map full
// master drives requests (traversal engine / bench), slave is the tracker.
interface eda_visit_tracker_if #(
  parameter int M     = eda_visit_tracker_pkg::DEF_M,
  parameter int N     = eda_visit_tracker_pkg::DEF_N,
  parameter int NPORT = eda_visit_tracker_pkg::DEF_NPORT
) ();
  import eda_visit_tracker_pkg::*;

  localparam int I_WIDTH    = clog2(M);
  localparam int J_WIDTH    = clog2(N);
  localparam int ADDR_WIDTH = I_WIDTH + J_WIDTH;
  localparam int CNT_WIDTH  = clog2(M * N + 1);

  logic                                 clear_req;
  logic                                 busy;
  logic [NPORT-1:0]                     mark_vld;
  logic [NPORT-1:0][ADDR_WIDTH-1:0]     mark_addr;
  logic [NPORT-1:0]                     qry_vld;
  logic [NPORT-1:0][ADDR_WIDTH-1:0]     qry_addr;
  logic [NPORT-1:0]                     qry_hit;
  logic                                 next_vld;
  logic [I_WIDTH-1:0]                   next_row;
  logic [J_WIDTH-1:0]                   next_col;
  logic                                 pop;
  logic [CNT_WIDTH-1:0]                 visited_cnt;
  logic                                 all_visited;

  modport master (
    output clear_req, mark_vld, mark_addr, qry_vld, qry_addr, pop,
    input  busy, qry_hit, next_vld, next_row, next_col, visited_cnt, all_visited
  );

  modport slave (
    input  clear_req, mark_vld, mark_addr, qry_vld, qry_addr, pop,
    output busy, qry_hit, next_vld, next_row, next_col, visited_cnt, all_visited
  );

endinterface

// File: rtl/eda_visit_tracker_first_one_finder.sv
// Lowest-index set-bit finder.
//   i_vec    : candidate vector
//   o_onehot : only the lowest set bit of i_vec
//   o_idx    : binary index of that bit (0 when nothing is set)
//   o_found  : i_vec has at least one set bit
module eda_first_one_finder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
  assign o_found  = |i_vec;

  // At most one bit of o_onehot is set, so OR-ing indices encodes it.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (o_onehot[i]) o_idx = o_idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/eda_visit_tracker.sv
// Visited-pixel tracker for an M x N image.
// Holds one visited bit per pixel, accepts up to NPORT marks plus one pop per
// cycle, answers NPORT combinational queries, keeps a running count of set
// bits and presents the first unvisited pixel in raster order (registered).
// A clear request sweeps the map one row per cycle while busy is high.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : eda_visit_tracker_if slave (marks, queries, next pixel, counts)
module eda_visit_tracker #(
  parameter int M     = eda_visit_tracker_pkg::DEF_M,
  parameter int N     = eda_visit_tracker_pkg::DEF_N,
  parameter int NPORT = eda_visit_tracker_pkg::DEF_NPORT
) (
  input logic                 clk,
  input logic                 reset_n,
  eda_visit_tracker_if.slave  bus
);
  import eda_visit_tracker_pkg::*;

  localparam int I_WIDTH    = clog2(M);
  localparam int J_WIDTH    = clog2(N);
  localparam int ADDR_WIDTH = I_WIDTH + J_WIDTH;
  localparam int CNT_WIDTH  = clog2(M * N + 1);

  localparam logic [I_WIDTH:0]     M_LIM = (I_WIDTH + 1)'(M);
  localparam logic [J_WIDTH:0]     N_LIM = (J_WIDTH + 1)'(N);
  localparam logic [CNT_WIDTH-1:0] TOTAL = CNT_WIDTH'(M * N);

  function automatic logic [I_WIDTH-1:0] f_row(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:J_WIDTH];
  endfunction

  function automatic logic [J_WIDTH-1:0] f_col(input logic [ADDR_WIDTH-1:0] a);
    return a[J_WIDTH-1:0];
  endfunction

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, f_row(a)} < M_LIM) && ({1'b0, f_col(a)} < N_LIM);
  endfunction

  state_e                    r_state, w_state_nxt;
  logic [I_WIDTH-1:0]        r_clr_row;
  logic [M-1:0][N-1:0]       r_map;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic                      r_all;
  logic                      r_next_vld;
  logic [I_WIDTH-1:0]        r_next_row;
  logic [J_WIDTH-1:0]        r_next_col;
  logic [M-1:0]              r_next_row_oh;
  logic [N-1:0]              r_next_col_oh;

  logic                      w_busy, w_accept, w_clr_go;
  logic [M-1:0][N-1:0]       w_set, w_new, w_map_nxt;
  logic [CNT_WIDTH-1:0]      w_new_cnt, w_cnt_nxt;
  logic [M-1:0]              w_row_free, w_row_oh;
  logic [N-1:0]              w_sel_row, w_col_free, w_col_oh;
  logic [I_WIDTH-1:0]        w_row_idx;
  logic [J_WIDTH-1:0]        w_col_idx;
  logic                      w_row_found, w_col_found;
  logic [NPORT-1:0]          w_qry_hit;

  assign w_busy   = (r_state == ST_CLEAR);
  // clear_req wins over marks/pops on the edge that enters CLEAR.
  assign w_clr_go = !w_busy && bus.clear_req;
  assign w_accept = !w_busy && !bus.clear_req;

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN) begin
      if (bus.clear_req) w_state_nxt = ST_CLEAR;
    end else if (r_clr_row == I_WIDTH'(M - 1)) begin
      w_state_nxt = ST_RUN;
    end
  end

  // Bits written this edge: in-range marks plus the claimed next pixel.
  always_comb begin
    w_set = '0;
    if (w_accept) begin
      for (int k = 0; k < NPORT; k++) begin
        if (bus.mark_vld[k] && f_in_range(bus.mark_addr[k]))
          w_set[f_row(bus.mark_addr[k])][f_col(bus.mark_addr[k])] = 1'b1;
      end
      if (bus.pop && r_next_vld) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            if (r_next_row_oh[i] && r_next_col_oh[j]) w_set[i][j] = 1'b1;
      end
    end
  end

  // Duplicates collapse in w_set, so counting 0->1 transitions counts once.
  assign w_new = w_set & ~r_map;

  always_comb begin
    w_new_cnt = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        w_new_cnt = w_new_cnt + CNT_WIDTH'(w_new[i][j]);
  end

  assign w_cnt_nxt = r_cnt + w_new_cnt;

  always_comb begin
    w_map_nxt = r_map | w_set;
    if (w_busy) w_map_nxt[r_clr_row] = '0;
  end

  // Next-pixel search runs on the post-write map so it registers with 1-cycle latency.
  always_comb begin
    for (int i = 0; i < M; i++) w_row_free[i] = ~&w_map_nxt[i];
  end

  eda_first_one_finder #(.WIDTH(M), .IDX_W(I_WIDTH)) u_row_sel (
    .i_vec    (w_row_free),
    .o_onehot (w_row_oh),
    .o_idx    (w_row_idx),
    .o_found  (w_row_found)
  );

  always_comb begin
    w_sel_row = '0;
    for (int i = 0; i < M; i++) if (w_row_oh[i]) w_sel_row = w_map_nxt[i];
  end

  assign w_col_free = ~w_sel_row;

  eda_first_one_finder #(.WIDTH(N), .IDX_W(J_WIDTH)) u_col_sel (
    .i_vec    (w_col_free),
    .o_onehot (w_col_oh),
    .o_idx    (w_col_idx),
    .o_found  (w_col_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_clr_row     <= '0;
      r_map         <= '0;
      r_cnt         <= '0;
      r_all         <= 1'b0;
      r_next_vld    <= 1'b0;
      r_next_row    <= '0;
      r_next_col    <= '0;
      r_next_row_oh <= '0;
      r_next_col_oh <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_map         <= w_map_nxt;
      r_clr_row     <= w_busy ? (r_clr_row + I_WIDTH'(1)) : '0;
      if (w_clr_go) begin
        r_cnt <= '0;
        r_all <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_all <= (w_cnt_nxt == TOTAL);
      end
      r_next_vld    <= w_accept && w_row_found && w_col_found;
      r_next_row    <= w_row_idx;
      r_next_col    <= w_col_idx;
      r_next_row_oh <= w_row_oh;
      r_next_col_oh <= w_col_oh;
    end
  end

  always_comb begin
    w_qry_hit = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (bus.qry_vld[k] && !w_busy && f_in_range(bus.qry_addr[k]))
        w_qry_hit[k] = r_map[f_row(bus.qry_addr[k])][f_col(bus.qry_addr[k])];
    end
  end

  assign bus.busy        = w_busy;
  assign bus.qry_hit     = w_qry_hit;
  assign bus.next_vld    = r_next_vld;
  assign bus.next_row    = r_next_row;
  assign bus.next_col    = r_next_col;
  assign bus.visited_cnt = r_cnt;
  assign bus.all_visited = r_all;

endmodule

// File: tb/tb_eda_visit_tracker.sv
// Bench for eda_visit_tracker: a 16x16 instance checked every cycle against a
// pixel-map model, a 4x4 instance for the raster pop walk and a 5x6 instance
// for out-of-range addresses.
module tb_eda_visit_tracker;
  import eda_visit_tracker_pkg::*;

  localparam int AM = 16;
  localparam int AN = 16;
  localparam int NP = 9;

  logic clk = 1'b0;
  logic rst_a_n = 1'b1;
  logic rst_b_n = 1'b1;
  logic rst_c_n = 1'b1;
  always #5 clk = ~clk;

  eda_visit_tracker_if #(.M(AM), .N(AN), .NPORT(NP)) bus_a ();
  eda_visit_tracker_if #(.M(4),  .N(4),  .NPORT(NP)) bus_b ();
  eda_visit_tracker_if #(.M(5),  .N(6),  .NPORT(NP)) bus_c ();

  eda_visit_tracker #(.M(AM), .N(AN), .NPORT(NP)) u_dut_a (.clk(clk), .reset_n(rst_a_n), .bus(bus_a));
  eda_visit_tracker #(.M(4),  .N(4),  .NPORT(NP)) u_dut_b (.clk(clk), .reset_n(rst_b_n), .bus(bus_b));
  eda_visit_tracker #(.M(5),  .N(6),  .NPORT(NP)) u_dut_c (.clk(clk), .reset_n(rst_c_n), .bus(bus_c));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_a  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pixel-map model of the 16x16 instance ----------------
  bit m_map [AM][AN];
  int m_cnt = 0;
  bit m_all = 1'b0;
  bit m_busy = 1'b0;
  bit m_nv = 1'b0;
  int m_nr = 0;
  int m_nc = 0;
  int m_clr_left = 0;

  always @(posedge clk or negedge rst_a_n) begin
    int r, c;
    if (!rst_a_n) begin
      foreach (m_map[i, j]) m_map[i][j] = 1'b0;
      m_cnt = 0; m_all = 0; m_busy = 0; m_nv = 0; m_nr = 0; m_nc = 0; m_clr_left = 0;
    end else if (m_busy) begin
      m_clr_left--;
      if (m_clr_left == 0) m_busy = 0;
      m_nv = 0;
    end else if (bus_a.clear_req) begin
      foreach (m_map[i, j]) m_map[i][j] = 1'b0;
      m_cnt = 0; m_all = 0; m_busy = 1; m_clr_left = AM; m_nv = 0;
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (bus_a.mark_vld[k]) begin
          r = int'(bus_a.mark_addr[k][7:4]);
          c = int'(bus_a.mark_addr[k][3:0]);
          if (r < AM && c < AN) m_map[r][c] = 1'b1;
        end
      end
      if (bus_a.pop && m_nv) m_map[m_nr][m_nc] = 1'b1;
      m_cnt = 0;
      foreach (m_map[i, j]) m_cnt += int'(m_map[i][j]);
      m_all = (m_cnt == AM * AN);
      m_nv = 0;
      for (int i = 0; i < AM; i++)
        for (int j = 0; j < AN; j++)
          if (!m_nv && !m_map[i][j]) begin m_nv = 1; m_nr = i; m_nc = j; end
    end
  end

  always @(negedge clk) begin
    logic exp_hit;
    if (chk_a) begin
      #2;
      check("a_busy", 32'(bus_a.busy), 32'(m_busy));
      check("a_visited_cnt", 32'(bus_a.visited_cnt), 32'(m_cnt));
      check("a_all_visited", 32'(bus_a.all_visited), 32'(m_all));
      check("a_next_vld", 32'(bus_a.next_vld), 32'(m_nv));
      if (m_nv) begin
        check("a_next_row", 32'(bus_a.next_row), 32'(m_nr));
        check("a_next_col", 32'(bus_a.next_col), 32'(m_nc));
      end
      for (int k = 0; k < NP; k++) begin
        exp_hit = bus_a.qry_vld[k] && !m_busy &&
                  m_map[int'(bus_a.qry_addr[k][7:4])][int'(bus_a.qry_addr[k][3:0])];
        check("a_qry_hit", 32'(bus_a.qry_hit[k]), 32'(exp_hit));
      end
    end
  end

  task automatic a_idle();
    bus_a.clear_req = 1'b0; bus_a.pop = 1'b0;
    bus_a.mark_vld = '0; bus_a.mark_addr = '0;
    bus_a.qry_vld = '0; bus_a.qry_addr = '0;
  endtask

  task automatic a_mark(input int k, input int r, input int c);
    bus_a.mark_vld[k] = 1'b1;
    bus_a.mark_addr[k] = {4'(r), 4'(c)};
  endtask

  task automatic a_qry(input int k, input int r, input int c);
    bus_a.qry_vld[k] = 1'b1;
    bus_a.qry_addr[k] = {4'(r), 4'(c)};
  endtask

  task automatic a_expect(input string tag, input int cnt, input int nv, input int nr, input int nc);
    check({tag, "_cnt"}, 32'(bus_a.visited_cnt), 32'(cnt));
    check({tag, "_next_vld"}, 32'(bus_a.next_vld), 32'(nv));
    check({tag, "_next_row"}, 32'(bus_a.next_row), 32'(nr));
    check({tag, "_next_col"}, 32'(bus_a.next_col), 32'(nc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    a_idle();
    bus_b.clear_req = 0; bus_b.pop = 0; bus_b.mark_vld = '0; bus_b.mark_addr = '0;
    bus_b.qry_vld = '0; bus_b.qry_addr = '0;
    bus_c.clear_req = 0; bus_c.pop = 0; bus_c.mark_vld = '0; bus_c.mark_addr = '0;
    bus_c.qry_vld = '0; bus_c.qry_addr = '0;
    #1;
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    chk_a = 1'b1;

    // Reset values
    @(negedge clk); #3;
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_all", 32'(bus_a.all_visited), 0);
    a_expect("rst", 0, 0, 0, 0);
    @(negedge clk); rst_a_n = 1'b1;
    @(posedge clk); #1;
    a_expect("post_rst", 0, 1, 0, 0);
    check("post_rst_all", 32'(bus_a.all_visited), 0);

    // Duplicate marks in one cycle count once
    @(negedge clk);
    a_mark(0, 0, 0); a_mark(1, 0, 0); a_mark(2, 0, 1); a_qry(0, 0, 1);
    @(posedge clk); #1;
    a_expect("dup", 2, 1, 0, 2);
    check("dup_qry01", 32'(bus_a.qry_hit[0]), 1);

    // Re-mark of a set bit, pop colliding with a mark, one fresh pixel
    @(negedge clk); a_idle();
    a_mark(0, 0, 1); a_mark(3, 0, 2); a_mark(4, 5, 9); a_mark(8, 5, 9); bus_a.pop = 1'b1;
    a_qry(1, 5, 9); a_qry(2, 5, 8); bus_a.qry_addr[5] = {4'd0, 4'd0};
    @(posedge clk); #1;
    a_expect("pop_mark", 4, 1, 0, 3);
    check("pop_mark_qry59", 32'(bus_a.qry_hit[1]), 1);
    check("pop_mark_qry58", 32'(bus_a.qry_hit[2]), 0);

    // Fill row 0 so the search advances to row 1
    @(negedge clk); a_idle(); bus_a.pop = 1'b1;
    for (int k = 0; k < NP; k++) a_mark(k, 0, 3 + k);
    @(posedge clk); #1;
    a_expect("row0a", 13, 1, 0, 12);
    @(negedge clk); a_idle();
    for (int k = 0; k < 4; k++) a_mark(k, 0, 12 + k);
    @(posedge clk); #1;
    a_expect("row0b", 17, 1, 1, 0);

    // Three consecutive pops
    @(negedge clk); a_idle(); bus_a.pop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_expect("pops", 20, 1, 1, 3);

    // Mark (3,5) then clear; clear_req held through busy must not restart it
    @(negedge clk); a_idle(); a_mark(0, 3, 5);
    @(posedge clk); #1;
    check("mark35_cnt", 32'(bus_a.visited_cnt), 21);
    @(negedge clk); a_idle(); bus_a.clear_req = 1'b1; a_qry(0, 3, 5);
    nbusy = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus_a.busy) begin
        nbusy++; a_mark(1, 7, 7); bus_a.pop = 1'b1;
      end else begin
        bus_a.clear_req = 1'b0; bus_a.mark_vld = '0; bus_a.pop = 1'b0;
        break;
      end
    end
    check("clear_busy_cycles", 32'(nbusy), 16);
    #1;
    check("clear_qry35", 32'(bus_a.qry_hit[0]), 0);
    check("clear_cnt", 32'(bus_a.visited_cnt), 0);
    check("clear_next_vld_low", 32'(bus_a.next_vld), 0);
    @(posedge clk); #1;
    a_expect("after_clear", 0, 1, 0, 0);

    // Reset in CLEAR cycle 5 aborts the sweep
    @(negedge clk); a_idle(); a_mark(0, 9, 9);
    @(negedge clk); a_idle(); bus_a.clear_req = 1'b1;
    repeat (6) @(negedge clk);
    check("midclr_busy_before", 32'(bus_a.busy), 1);
    bus_a.clear_req = 1'b0; a_qry(0, 9, 9); rst_a_n = 1'b0;
    #1;
    check("midclr_busy", 32'(bus_a.busy), 0);
    check("midclr_all", 32'(bus_a.all_visited), 0);
    check("midclr_qry99", 32'(bus_a.qry_hit[0]), 0);
    a_expect("midclr", 0, 0, 0, 0);
    @(negedge clk); rst_a_n = 1'b1;
    @(posedge clk); #1;
    a_expect("midclr_rel", 0, 1, 0, 0);
    @(negedge clk); chk_a = 1'b0;

    // 4x4: pop every cycle from reset release walks raster order
    bus_b.pop = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;
    check("b_first_vld", 32'(bus_b.next_vld), 1);
    check("b_first_row", 32'(bus_b.next_row), 0);
    check("b_first_col", 32'(bus_b.next_col), 0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check("b_cnt", 32'(bus_b.visited_cnt), 32'(k));
      check("b_all", 32'(bus_b.all_visited), 32'(k == 16));
      check("b_next_vld", 32'(bus_b.next_vld), 32'(k < 16));
      if (k < 16) begin
        check("b_next_row", 32'(bus_b.next_row), 32'(k / 4));
        check("b_next_col", 32'(bus_b.next_col), 32'(k % 4));
      end
    end
    @(negedge clk); bus_b.pop = 1'b0;

    // 5x6: row >= M or col >= N is ignored
    rst_c_n = 1'b1;
    @(posedge clk); #1;
    check("c_first_vld", 32'(bus_c.next_vld), 1);
    @(negedge clk);
    bus_c.mark_vld = 9'b0_0000_1111;
    bus_c.mark_addr[0] = {3'd5, 3'd0};
    bus_c.mark_addr[1] = {3'd7, 3'd2};
    bus_c.mark_addr[2] = {3'd1, 3'd6};
    bus_c.mark_addr[3] = {3'd6, 3'd7};
    bus_c.qry_vld = 9'b0_0000_0111;
    bus_c.qry_addr[0] = {3'd5, 3'd0};
    bus_c.qry_addr[1] = {3'd7, 3'd2};
    bus_c.qry_addr[2] = {3'd1, 3'd6};
    @(posedge clk); #1;
    check("c_oor_cnt", 32'(bus_c.visited_cnt), 0);
    check("c_oor_next_vld", 32'(bus_c.next_vld), 1);
    check("c_oor_next_row", 32'(bus_c.next_row), 0);
    check("c_oor_next_col", 32'(bus_c.next_col), 0);
    check("c_oor_qry", 32'(bus_c.qry_hit), 0);
    @(negedge clk);
    bus_c.mark_vld = 9'b0_0000_0001; bus_c.mark_addr[0] = {3'd4, 3'd5};
    bus_c.qry_vld = 9'b0_0000_0001; bus_c.qry_addr[0] = {3'd4, 3'd5};
    @(posedge clk); #1;
    check("c_last_cnt", 32'(bus_c.visited_cnt), 1);
    check("c_last_qry", 32'(bus_c.qry_hit[0]), 1);
    @(negedge clk);
    bus_c.mark_vld = 9'b0_0011_1111;
    for (int k = 0; k < 6; k++) bus_c.mark_addr[k] = {3'd0, 3'(k)};
    @(posedge clk); #1;
    check("c_row0_cnt", 32'(bus_c.visited_cnt), 7);
    check("c_row0_next_row", 32'(bus_c.next_row), 1);
    check("c_row0_next_col", 32'(bus_c.next_col), 0);
    @(negedge clk); bus_c.mark_vld = '0; bus_c.qry_vld = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eda_visit_tracker.md
EDA_VISIT_TRACKER -- requirements
Module: eda_visit_tracker

Interface
REQ-001 SHALL have parameter M, default 16, image rows.
REQ-002 SHALL have parameter N, default 16, image columns.
REQ-003 SHALL have parameter NPORT, default 9, number of mark/query ports (centre plus 8 neighbours).
REQ-004 SHALL derive I_WIDTH = clog2(M), J_WIDTH = clog2(N), ADDR_WIDTH = I_WIDTH + J_WIDTH, CNT_WIDTH = clog2(M*N+1); address packing {row, col}.
REQ-005 SHALL have clk input 1, clock; all flops on rising edge only, no inverted clock.
REQ-006 SHALL have reset_n input 1, asynchronous, active-low reset.
REQ-007 SHALL have clear_req input 1, start row-sequential clear.
REQ-008 SHALL have busy output 1, clear in progress.
REQ-009 SHALL have mark_vld input [NPORT], per-port mark strobe.
REQ-010 SHALL have mark_addr input [NPORT][ADDR_WIDTH], mark addresses.
REQ-011 SHALL have qry_vld input [NPORT], per-port query enable.
REQ-012 SHALL have qry_addr input [NPORT][ADDR_WIDTH], query addresses.
REQ-013 SHALL have qry_hit output [NPORT], visited bit per port.
REQ-014 SHALL have next_vld output 1, an unvisited pixel exists.
REQ-015 SHALL have next_row output I_WIDTH and next_col output J_WIDTH, first unvisited pixel in raster order.
REQ-016 SHALL have pop input 1, claim the presented next pixel.
REQ-017 SHALL have visited_cnt output CNT_WIDTH, number of set bits.
REQ-018 SHALL have all_visited output 1, visited_cnt == M*N.

Function
REQ-019 SHALL hold an M x N bit map; bit set = visited.
REQ-020 SHALL, on a rising edge in RUN, set every bit addressed by a port with mark_vld=1; out-of-range addresses (row>=M or col>=N) are ignored.
REQ-021 SHALL, when pop=1 and next_vld=1 in RUN, set the bit at {next_row, next_col} on that edge; pop with next_vld=0 is ignored.
REQ-022 SHALL drive qry_hit[k] combinationally from the map as of the last edge; 0 if qry_vld[k]=0, address out of range, or busy=1.
REQ-023 SHALL register next_vld/next_row/next_col each edge from the map state after that edge's writes (1-cycle latency); lowest row wins, then lowest column.
REQ-024 SHALL increment visited_cnt by the count of bits newly set 0->1 in a cycle; duplicate addresses across ports/pop in one cycle count once; already-set bits count zero.
REQ-025 SHALL use states RUN and CLEAR; RUN --clear_req--> CLEAR; CLEAR clears one row per cycle, rows 0..M-1, then -> RUN after exactly M cycles.
REQ-026 SHALL hold busy=1 throughout CLEAR, drop all marks and pops, force next_vld=0, and zero visited_cnt on entering CLEAR.
REQ-027 SHALL ignore clear_req while busy=1 (no restart).
REQ-028 SHALL, on the first RUN cycle after clear, present next_vld=1, next={0,0} one edge later.
REQ-029 SHALL never let visited_cnt exceed M*N; all_visited registered alongside visited_cnt.

Reset
REQ-030 SHALL on reset_n=0 clear the map, state=RUN, busy=0, visited_cnt=0, all_visited=0, next_vld=0, next_row=0, next_col=0.
REQ-031 SHALL, after reset release, present next_vld=1 at {0,0} after the first edge.
REQ-032 SHALL allow reset mid-CLEAR; it aborts the sweep and takes the REQ-030 values.

Structure
REQ-033 SHALL take M/N defaults, address-width functions and the state enum from eda_global_define/shared package.
REQ-034 SHALL instantiate sub-module eda_first_one_finder (parametric width, one-hot plus binary index, found flag) for row select and column select.

Verification
REQ-035 Reset, no stimulus -> next_vld=1, next=(0,0), visited_cnt=0, all_visited=0.
REQ-036 Ports 0,1,2 mark (0,0),(0,0),(0,1) same cycle -> visited_cnt=2, next=(0,2) next cycle, qry_hit at (0,1)=1.
REQ-037 pop every cycle from reset on 4x4 -> 16 pops visit raster order, all_visited=1 and next_vld=0 after the 16th.
REQ-038 Mark (3,5) with M=N=16, then clear_req -> busy=1 for 16 cycles, marks dropped, then qry (3,5)=0, visited_cnt=0.
REQ-039 Mark address row=M -> no bit set, visited_cnt unchanged.
REQ-040 reset_n asserted at CLEAR cycle 5 -> REQ-030 values, busy=0 immediately.
